// File: rtl/mealy_pkg.sv
// Shared FSM encoding and default widths for the Mealy sequence scheduler.
package mealy_pkg;
  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
endpackage

// File: rtl/mealy_bit_serializer.sv
// Holds the latched pattern and run length; shifts one bit out per RUN cycle, LSB first.
// last is high while the final bit of the clamped length is on bit_out.
module mealy_bit_serializer
  import mealy_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             bit_out,
  output logic             last
);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] shreg;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len_q;

  // Lengths beyond the pattern width are clamped so a run never exceeds PAT_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
      len_q <= '0;
    end else if (load) begin
      shreg <= pattern;
      idx   <= '0;
      len_q <= (len > LEN_MAX) ? LEN_MAX : len;
    end else if (advance) begin
      shreg <= shreg >> 1;
      idx   <= idx + LEN_W'(1);
    end
  end

  assign bit_out = shreg[0];
  assign last    = (idx == len_q - LEN_W'(1));
endmodule

// File: rtl/mealy_seq_scheduler.sv
// Feeds a bit pattern into an external Mealy detector and counts its hits per run.
// Optional HIT_LOG_EN adds hit_mask, a per-bit record of which RUN cycles produced a hit.
module mealy_seq_scheduler
  import mealy_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [PAT_W-1:0]             pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   len,
  input  logic                         det_z,
  output logic                         det_x,
  output logic                         det_rst,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted,
  output logic [CNT_W-1:0]             hit_cnt
`ifdef HIT_LOG_EN
  ,
  output logic [PAT_W-1:0]             hit_mask
`endif
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   ser_bit;
  logic   ser_last;

  assign accept = (state == IDLE) && start;

  mealy_bit_serializer #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (accept && (len != '0)),
    .advance (state == RUN),
    .pattern (pattern),
    .len     (len),
    .bit_out (ser_bit),
    .last    (ser_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (ser_last || abort) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // det_rst is registered so it stays high through reset and drops on the first edge after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      det_rst <= 1'b1;
      hit_cnt <= '0;
      aborted <= 1'b0;
    end else begin
      state   <= state_nxt;
      det_rst <= (state_nxt == CLEAR);
      if (accept) begin
        hit_cnt <= '0;
        aborted <= 1'b0;
      end else if (state == RUN) begin
        if (det_z && (hit_cnt != {CNT_W{1'b1}})) hit_cnt <= hit_cnt + CNT_W'(1);
        if (abort && !ser_last) aborted <= 1'b1;
      end
    end
  end

  assign det_x = (state == RUN) && ser_bit;
  assign busy  = (state == CLEAR) || (state == RUN);
  assign done  = (state == DONE);

`ifdef HIT_LOG_EN
  logic [PAT_W-1:0] hit_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_mask <= '0;
      hit_pos  <= '0;
    end else if (accept) begin
      hit_mask <= '0;
      hit_pos  <= PAT_W'(1);
    end else if (state == RUN) begin
      if (det_z) hit_mask <= hit_mask | hit_pos;
      hit_pos <= hit_pos << 1;
    end
  end
`endif
endmodule

// File: tb/tb_mealy_seq_scheduler.sv
// Directed bench: drives the scheduler against a 3-bit-frame odd-parity Mealy detector model.
module tb_mealy_seq_scheduler;
  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       det_z;
  logic       det_x;
  logic       det_rst;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [3:0] hit_cnt;
`ifdef HIT_LOG_EN
  logic [7:0] hit_mask;
`endif

  int checks = 0;
  int errors = 0;

  mealy_seq_scheduler #(.PAT_W(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .len     (len),
    .det_z   (det_z),
    .det_x   (det_x),
    .det_rst (det_rst),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .hit_cnt (hit_cnt)
`ifdef HIT_LOG_EN
    ,
    .hit_mask(hit_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector: 0 = frame start, 1/2 = one bit seen (parity 0/1), 3/4 = two bits seen (parity 0/1)
  logic [2:0] dst = 3'd0;
  always_comb det_z = ((dst == 3'd3) && det_x) || ((dst == 3'd4) && !det_x);
  always_ff @(posedge clk) begin
    if (det_rst) dst <= 3'd0;
    else begin
      case (dst)
        3'd0:    dst <= det_x ? 3'd2 : 3'd1;
        3'd1:    dst <= det_x ? 3'd4 : 3'd3;
        3'd2:    dst <= det_x ? 3'd3 : 3'd4;
        default: dst <= 3'd0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One run; cycle numbers count negedges after the one where start is driven.
  task automatic run_seq(input logic [7:0] pat, input logic [3:0] l, input int abort_at,
                         input bit hold, output int done_cyc, output int run_cyc,
                         output logic [7:0] xs, output bit busy_seen);
    int k;
    done_cyc = -1; run_cyc = 0; xs = '0; busy_seen = 0; k = 0;
    @(negedge clk);
    pattern = pat; len = l; start = 1'b1;
    for (int n = 1; n <= 40 && done_cyc < 0; n++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      abort = 1'b0;
      if (busy) busy_seen = 1;
      if (busy && !det_rst) begin
        if (k < 8) xs = xs | (8'(det_x) << k);
        run_cyc++;
        if (k == abort_at) abort = 1'b1;
        k++;
      end
      if (done) begin
        done_cyc = n;
        start = 1'b0;
      end
    end
  endtask

  int         dc;
  int         rc;
  logic [7:0] xs;
  bit         bs;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; len = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_det_rst", det_rst, 1);
    check("rst_det_x", det_x, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_aborted", aborted, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_det_rst", det_rst, 0);

    run_seq(8'h04, 4'd3, -1, 0, dc, rc, xs, bs);
    check("p04_done_cyc", dc, 5);
    check("p04_xs", xs, 8'h04);
    check("p04_run_cyc", rc, 3);
    check("p04_hit_cnt", hit_cnt, 1);
    check("p04_aborted", aborted, 0);

    run_seq(8'h00, 4'd6, -1, 1, dc, rc, xs, bs);
    check("p00_done_cyc", dc, 8);
    check("p00_run_cyc", rc, 6);
    check("p00_hit_cnt", hit_cnt, 0);
    check("p00_aborted", aborted, 0);

    run_seq(8'hFF, 4'd6, -1, 0, dc, rc, xs, bs);
    check("pff_done_cyc", dc, 8);
    check("pff_hit_cnt", hit_cnt, 2);
`ifdef HIT_LOG_EN
    check("pff_hit_mask", hit_mask, 8'h24);
`endif

    run_seq(8'hFF, 4'd0, -1, 0, dc, rc, xs, bs);
    check("len0_done_cyc", dc, 1);
    check("len0_busy_seen", bs, 0);
    check("len0_hit_cnt", hit_cnt, 0);
`ifdef HIT_LOG_EN
    check("len0_hit_mask", hit_mask, 0);
`endif

    run_seq(8'h1C, 4'd12, -1, 0, dc, rc, xs, bs);
    check("len12_run_cyc", rc, 8);
    check("len12_done_cyc", dc, 10);
    check("len12_xs", xs, 8'h1C);
    check("len12_hit_cnt", hit_cnt, 1);
`ifdef HIT_LOG_EN
    check("len12_hit_mask", hit_mask, 8'h04);
`endif

    run_seq(8'hFF, 4'd6, 2, 0, dc, rc, xs, bs);
    check("abort_done_cyc", dc, 5);
    check("abort_run_cyc", rc, 3);
    check("abort_aborted", aborted, 1);
    check("abort_hit_cnt", hit_cnt, 1);
    repeat (2) @(negedge clk);
    check("abort_hold_aborted", aborted, 1);
    check("abort_hold_hit_cnt", hit_cnt, 1);
    check("abort_hold_done", done, 0);

    run_seq(8'h04, 4'd3, 2, 0, dc, rc, xs, bs);
    check("abort_last_done_cyc", dc, 5);
    check("abort_last_aborted", aborted, 0);
    check("abort_last_hit_cnt", hit_cnt, 1);

    // Reset during RUN cycle 3 of an 8'hFF run, after the first hit was counted.
    @(negedge clk);
    pattern = 8'hFF; len = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    check("midrst_hit_before", hit_cnt, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_det_x", det_x, 0);
    check("midrst_det_rst", det_rst, 1);
    check("midrst_hit_cnt", hit_cnt, 0);
    check("midrst_aborted", aborted, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release_det_rst_hold", det_rst, 1);
    @(posedge clk); #1;
    check("midrst_release_det_rst", det_rst, 0);
    check("midrst_release_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
